// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    localparam int unsigned DIV_WIDTH = 6;

    // Iteration counter width: one restoring step per dividend bit.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/div_neg_abs.sv
// Two's-complement magnitude / conditional negate, one extra bit wide so the
// most-negative input maps to an exact positive magnitude.
module neg_abs
    import div_pkg::*;
#(
    parameter int unsigned width = DIV_WIDTH
) (
    input  logic [width-1:0] value,
    input  logic             is_signed,
    input  logic             neg_en,
    output logic [width:0]   result,
    output logic             sign
);

    logic [width:0] ext;
    logic           do_neg;

    // Signed mode returns |value|; unsigned mode negates on neg_en.
    always_comb begin
        sign   = is_signed & value[width-1];
        ext    = {sign, value};
        do_neg = is_signed ? sign : neg_en;
        result = do_neg ? (~ext + 1'b1) : ext;
    end

endmodule

// File: rtl/div_top.sv
// Sequential signed restoring divider: 2*width-bit dividend by width-bit
// divisor, one quotient bit per clock, start/busy/done handshake.
module div_top
    import div_pkg::*;
#(
    parameter int unsigned width = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*width-1:0]   dividend,
    input  logic [width-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*width-1:0]   quotient,
    output logic [width-1:0]     remainder,
    output logic                 overflow,
    output logic                 div_by_zero
);

    localparam int unsigned W2 = 2 * width;
    localparam int unsigned CW = cnt_bits(width);
    localparam logic [CW-1:0] LAST_STEP = CW'(W2 - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [width:0]    rem_q, rem_d;
    logic [width:0]    dvs_q, dvs_d;
    logic              dvd_neg_q, dvd_neg_d;
    logic              quo_neg_q, quo_neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W2-1:0]     quotient_q, quotient_d;
    logic [width-1:0]  remainder_q, remainder_d;
    logic              overflow_q, overflow_d;
    logic              dbz_q, dbz_d;

    logic [W2:0]       dvd_mag;
    logic              dvd_sign;
    logic [width:0]    dvs_mag;
    logic              dvs_sign;
    logic [W2:0]       quo_fix;
    logic              quo_fix_sign;
    logic [width+1:0]  rem_fix;
    logic              rem_fix_sign;
    logic [width:0]    rem_shift;
    logic [width+1:0]  trial;
    logic              unused_ok;

    neg_abs #(.width(W2)) u_abs_dividend (
        .value     (dividend),
        .is_signed (1'b1),
        .neg_en    (1'b0),
        .result    (dvd_mag),
        .sign      (dvd_sign)
    );

    neg_abs #(.width(width)) u_abs_divisor (
        .value     (divisor),
        .is_signed (1'b1),
        .neg_en    (1'b0),
        .result    (dvs_mag),
        .sign      (dvs_sign)
    );

    neg_abs #(.width(W2)) u_fix_quotient (
        .value     (acc_q),
        .is_signed (1'b0),
        .neg_en    (quo_neg_q),
        .result    (quo_fix),
        .sign      (quo_fix_sign)
    );

    neg_abs #(.width(width + 1)) u_fix_remainder (
        .value     (rem_q),
        .is_signed (1'b0),
        .neg_en    (dvd_neg_q),
        .result    (rem_fix),
        .sign      (rem_fix_sign)
    );

    // |remainder| < |divisor|, so the top bits of the fixed remainder are redundant.
    assign unused_ok = ^{quo_fix_sign, rem_fix_sign, rem_fix[width+1:width]};

    always_comb begin
        // NOTE: every _d gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        dvd_neg_d   = dvd_neg_q;
        quo_neg_d   = quo_neg_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;

        // acc_q shifts dividend bits out the top and quotient bits in the bottom.
        rem_shift = {rem_q[width-1:0], acc_q[W2-1]};
        trial     = {1'b0, rem_shift} - {1'b0, dvs_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    overflow_d = 1'b0;
                    dbz_d      = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '0;
                        remainder_d = '0;
                    end else begin
                        state_d   = CALC;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        acc_d     = dvd_mag[W2-1:0];
                        rem_d     = {{width{1'b0}}, dvd_mag[W2]};
                        dvs_d     = dvs_mag;
                        dvd_neg_d = dvd_sign;
                        quo_neg_d = dvd_sign ^ dvs_sign;
                    end
                end
            end
            CALC: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (!trial[width+1]) begin
                    rem_d = trial[width:0];
                    acc_d = {acc_q[W2-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    acc_d = {acc_q[W2-2:0], 1'b0};
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d     = DONE;
                done_d      = 1'b1;
                quotient_d  = quo_fix[W2-1:0];
                remainder_d = rem_fix[width-1:0];
                // Only -2^(W2-1) / -1 yields a positive magnitude that needs W2+1 bits.
                overflow_d  = quo_fix[W2] ^ quo_fix[W2-1];
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dvd_neg_q   <= 1'b0;
            quo_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            dvd_neg_q   <= dvd_neg_d;
            quo_neg_q   <= quo_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_top.sv
// Scoreboard bench for div_top: stimulus pushes arithmetic-model results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_top;

    localparam int W  = 6;
    localparam int W2 = 2 * W;

    typedef struct {
        logic [W2-1:0] q;
        logic [W-1:0]  r;
        logic          ovf;
        logic          dbz;
        int            done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W2-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W2-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          overflow;
    logic          div_by_zero;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;

    div_top #(.width(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    function automatic exp_t model(input logic [W2-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        int a, b, q, r;
        a = int'($signed(dd));
        b = int'($signed(dv));
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        if (b == 0) begin
            q = 0;
            r = 0;
            e.dbz = 1'b1;
        end else if (a == -(1 << (W2 - 1)) && b == -1) begin
            q = -(1 << (W2 - 1));
            r = 0;
            e.ovf = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        e.q = q[W2-1:0];
        e.r = r[W-1:0];
        e.done_cyc = 0;
        return e;
    endfunction

    // Waits for busy=0, drives start for one edge; returns one edge after acceptance.
    task automatic issue(input logic [W2-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        if (busy) begin
            check("accept_timeout", busy, 1'b0);
            return;
        end
        e = model(dd, dv);
        e.done_cyc = cyc + ((dv == '0) ? 1 : W2 + 2);
        sb.push_back(e);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("overflow", overflow, mon_e.ovf);
                check("div_by_zero", div_by_zero, mon_e.dbz);
                check("latency", cyc, mon_e.done_cyc);
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic busy_ok;
        logic saw_done;
        logic [W2-1:0] dd;
        logic [W-1:0]  dv;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, quotient, remainder, overflow, div_by_zero}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 35/5 with explicit busy window and done edge.
        issue(12'd35, 6'd5);
        busy_ok = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("busy_window", busy_ok, 1'b1);
        check("done_at_edge14", {busy, done}, 2'b01);

        issue(-12'sd35, 6'd6);
        issue(12'd100, -6'sd7);
        issue(12'h800, 6'h3f);
        issue(12'd17, 6'd0);
        issue(12'd35, 6'd5);
        check("dbz_cleared_on_accept", div_by_zero, 1'b0);

        // start while busy must be ignored.
        issue(12'd35, 6'd5);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = 12'd9;
        divisor  = 6'd3;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset mid-operation aborts without a done pulse.
        issue(12'd100, -6'sd7);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("mid_op_reset_outputs", {busy, done, quotient, remainder, overflow, div_by_zero}, '0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_reset", saw_done, 1'b0);

        // Randomized back-to-back stream with boundary-biased operands.
        for (int n = 0; n < 40; n++) begin
            dd = W2'($urandom);
            if ($urandom_range(0, 5) == 0) dd = 12'h800;
            case ($urandom_range(0, 7))
                0:       dv = 6'h00;
                1:       dv = 6'h3f;
                2:       dv = 6'h20;
                3:       dv = 6'h01;
                default: dv = W'($urandom);
            endcase
            issue(dd, dv);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", sb.size(), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_top.md
Name: div_top

Overview:
- Sequential signed integer divider; the inverse companion to the team's combinational multiplier.
- Dividend is 2*width bits wide, the same shape as the multiplier product. Divisor is width bits wide.
- Produces quotient and remainder by restoring division, one quotient bit per clock.
- Uses a start/busy/done handshake so a controller can chain multiply-then-divide datapaths.

Parameters:
- width, 6, operand width. Divisor and remainder are width bits; dividend and quotient are 2*width bits.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division. Sampled only when busy=0.
- dividend  input  2*width  two's-complement dividend; captured on the accepting edge.
- divisor  input  width  two's-complement divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: results are valid.
- quotient  output  2*width  two's-complement quotient, truncated toward zero.
- remainder  output  width  two's-complement remainder; its sign follows the dividend.
- overflow  output  1  the quotient was not representable.
- div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset: the synchronous reset (rst) forces state IDLE. busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0. Reset mid-operation aborts immediately; no done pulse is produced.
- Operands are captured on the edge where start=1 and busy=0. start while busy=1 is ignored, with no effect on the operation in flight.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE --start--> CALC. If divisor==0: IDLE --start--> DONE.
  - CALC: iteration counter runs 0..2*width-1, one restoring step per cycle on magnitudes. Counter wrap --> FIX.
  - FIX: apply signs. quotient is negated if the dividend and divisor signs differ. remainder is negated if the dividend is negative. --> DONE.
  - DONE: done=1 for exactly one cycle, busy=0. The next state is IDLE, or CALC/DONE if start=1 in this cycle (back-to-back operation allowed).
- busy=1 exactly in CALC and FIX.
- Latency:
  - Normal division: done is high in the cycle 2*width+2 edges after the accepting edge (14 for width=6).
  - Divide by zero: done is high 1 edge after acceptance.
- Magnitudes:
  - Dividend magnitude is computed in 2*width+1 bits so that the most-negative dividend is handled exactly.
  - Divisor magnitude is computed in width+1 bits.
  - Partial-remainder register is width+1 bits.
- Overflow:
  - Only case: dividend = -2^(2*width-1) and divisor = -1.
  - Required result: overflow=1, quotient = -2^(2*width-1) (wrapped bit pattern), remainder=0.
- Divide by zero: div_by_zero=1, quotient=0, remainder=0, overflow=0.
- Results, overflow and div_by_zero update only on the edge entering DONE. They hold stable until the next reset or the next DONE entry. The flags are cleared when a new operation is accepted.
- The |remainder| < |divisor| <= 2^(width-1) bound always holds, so the remainder always fits in width bits signed.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the counter width constant clog2(2*width).
- One natural sub-module, neg_abs: parameterised width. Outputs are magnitude (width+1 bits) and sign of a two's-complement input, plus conditional negate for the FIX stage. It is instantiated for dividend, divisor, quotient and remainder.

Test Plan (width=6):
- dividend=35, divisor=5, start one cycle -> done at edge 14; quotient=12'd7, remainder=0, flags 0; busy high for edges 1..13.
- dividend=-35, divisor=6 -> quotient=12'hFFB (-5), remainder=6'b111011 (-5).
- dividend=100, divisor=-7 -> quotient=12'hFF2 (-14), remainder=2.
- dividend=12'h800 (-2048), divisor=-1 -> overflow=1, quotient=12'h800, remainder=0.
- dividend=17, divisor=0 -> done at edge 1, div_by_zero=1, quotient=0, remainder=0. A following 35/5 then clears div_by_zero and returns 7 r 0.
- Handshake/reset checks:
  - Start 35/5. Pulse start with 9/3 at edge 5 -> ignored; the result is still 7 r 0.
  - Assert rst at edge 8 -> all outputs 0, no done pulse.
  - Back-to-back: start asserted during DONE -> the second result is done 14 edges later.
